// File: rtl/lane_pkg.sv
// Shared lane definitions for the round-robin lane arbiter and its helpers.
package lane_pkg;

    localparam int LANE_DW   = 8;
    localparam int NUM_LANES = 4;

    typedef logic [1:0] lane_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Lane indices are 2 bits wide, so 3 -> 0 falls out of the truncation.
    function automatic lane_idx_t lane_next(input lane_idx_t idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/lane_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first requesting lane at or after ptr_i (mod 4).
module rr_pick
    import lane_pkg::*;
(
    input  logic [NUM_LANES-1:0] req_i,
    input  lane_idx_t            ptr_i,
    output logic                 found_o,
    output lane_idx_t            idx_o
);

    logic [NUM_LANES-1:0] req_rot;
    lane_idx_t            offset;

    // Rotate so bit 0 is the lane at ptr_i; a plain LSB-first search then gives RR order.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_rot
        assign req_rot[gi] = req_i[ptr_i + lane_idx_t'(gi)];
    end

    always_comb begin
        offset = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = lane_idx_t'(k);
            end
        end
    end

    assign found_o = |req_rot;
    assign idx_o   = ptr_i + offset;

endmodule

// File: rtl/lane_rr_arbiter.sv
// Four-to-one round-robin lane arbiter with bounded bursts and a registered output stage.
// Optional per-lane accepted-beat counters are built when LANE_RR_ARBITER_STATS_EN is defined.
module lane_rr_arbiter
    import lane_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int DW        = LANE_DW
) (
    input  logic          clk_f,
    input  logic          reset,
    input  logic [DW-1:0] data_0,
    input  logic [DW-1:0] data_1,
    input  logic [DW-1:0] data_2,
    input  logic [DW-1:0] data_3,
    input  logic          valid_0,
    input  logic          valid_1,
    input  logic          valid_2,
    input  logic          valid_3,
    output logic          ready_0,
    output logic          ready_1,
    output logic          ready_2,
    output logic          ready_3,
    output logic [DW-1:0] data_out,
    output logic          valid_out,
    input  logic          ready_in,
    output logic [1:0]    grant,
    output logic          busy
`ifdef LANE_RR_ARBITER_STATS_EN
    ,
    output logic [15:0]   beats_0,
    output logic [15:0]   beats_1,
    output logic [15:0]   beats_2,
    output logic [15:0]   beats_3
`endif
);

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    arb_state_t           state_q, state_d;
    lane_idx_t            ptr_q, ptr_d;
    lane_idx_t            grant_q, grant_d;
    logic [3:0]           burst_cnt_q, burst_cnt_d;
    logic [DW-1:0]        data_out_q, data_out_d;
    logic                 valid_out_q, valid_out_d;

    logic [DW-1:0]        lane_data [NUM_LANES];
    logic [NUM_LANES-1:0] lane_valid;
    logic [NUM_LANES-1:0] lane_ready;
    logic                 load_en;
    logic                 valid_g;
    logic                 xfer;
    logic                 pick_found;
    lane_idx_t            pick_idx;

    assign lane_data[0] = data_0;
    assign lane_data[1] = data_1;
    assign lane_data[2] = data_2;
    assign lane_data[3] = data_3;
    assign lane_valid   = {valid_3, valid_2, valid_1, valid_0};

    // The output register can take a new beat if it is empty or being drained now.
    assign load_en = !valid_out_q || ready_in;
    assign valid_g = lane_valid[grant_q];
    assign xfer    = (state_q == BURST) && load_en && valid_g;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_ready
        assign lane_ready[gi] = (state_q == BURST) && load_en && (grant_q == lane_idx_t'(gi));
    end

    assign ready_0 = lane_ready[0];
    assign ready_1 = lane_ready[1];
    assign ready_2 = lane_ready[2];
    assign ready_3 = lane_ready[3];

    rr_pick u_rr_pick (
        .req_i   (lane_valid),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d     = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    if (burst_cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                        ptr_d   = lane_next(grant_q);
                    end
                end else if (load_en && !valid_g) begin
                    // Requester ran dry; a stall (load_en low) keeps the burst open.
                    state_d = IDLE;
                    ptr_d   = lane_next(grant_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        if (load_en) begin
            valid_out_d = xfer;
            if (xfer) begin
                data_out_d = lane_data[grant_q];
            end
        end
    end

    always_ff @(posedge clk_f) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign grant     = grant_q;
    assign busy      = (state_q == BURST);

`ifdef LANE_RR_ARBITER_STATS_EN
    logic [15:0] beats_q [NUM_LANES];

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_stats
        always_ff @(posedge clk_f) begin
            if (reset) begin
                beats_q[gi] <= '0;
            end else if (xfer && (grant_q == lane_idx_t'(gi)) && (beats_q[gi] != 16'hFFFF)) begin
                beats_q[gi] <= beats_q[gi] + 16'd1;
            end
        end
    end

    assign beats_0 = beats_q[0];
    assign beats_1 = beats_q[1];
    assign beats_2 = beats_q[2];
    assign beats_3 = beats_q[3];
`endif

endmodule

// File: tb/tb_lane_rr_arbiter.sv
// Self-checking bench for lane_rr_arbiter: directed scenarios plus randomized traffic
// scored against a transaction-level round-robin model (stats ports when LANE_RR_ARBITER_STATS_EN).
module tb_lane_rr_arbiter;

    localparam int MB  = 4;
    localparam int TRN = 128;

    logic        clk_f = 1'b0;
    logic        reset;
    logic [7:0]  d_in [4];
    logic [3:0]  v_in;
    logic        ready_in;
    logic [3:0]  r_out;
    logic [7:0]  data_out;
    logic        valid_out;
    logic [1:0]  grant;
    logic        busy;
`ifdef LANE_RR_ARBITER_STATS_EN
    logic [15:0] beats [4];
`endif

    always #5 clk_f = ~clk_f;

    lane_rr_arbiter #(.MAX_BURST(MB), .DW(8)) dut (
        .clk_f     (clk_f),
        .reset     (reset),
        .data_0    (d_in[0]),
        .data_1    (d_in[1]),
        .data_2    (d_in[2]),
        .data_3    (d_in[3]),
        .valid_0   (v_in[0]),
        .valid_1   (v_in[1]),
        .valid_2   (v_in[2]),
        .valid_3   (v_in[3]),
        .ready_0   (r_out[0]),
        .ready_1   (r_out[1]),
        .ready_2   (r_out[2]),
        .ready_3   (r_out[3]),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .grant     (grant),
        .busy      (busy)
`ifdef LANE_RR_ARBITER_STATS_EN
        ,
        .beats_0   (beats[0]),
        .beats_1   (beats[1]),
        .beats_2   (beats[2]),
        .beats_3   (beats[3])
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    // Source queues: bit 8 set marks a one-cycle gap with valid low.
    logic [8:0]  srcq [4][$];
    logic [7:0]  out_q [$];
    logic [7:0]  exp_q [$];
    logic        use_exp;
    logic        rnd_rin;
    logic        rin_pat [TRN];
    logic        tr_v [TRN];
    logic [7:0]  tr_d [TRN];
    logic [1:0]  tr_g [TRN];
    logic        tr_b [TRN];
    logic [3:0]  tr_r [TRN];
    logic [3:0]  hs;
    logic [3:0]  gap_drv;
    int          acc_cnt [4];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input int s, input logic v, input logic [7:0] d);
        chk($sformatf("%s_s%0d_vout", tag, s), 16'(tr_v[s]), 16'(v));
        if (v) chk($sformatf("%s_s%0d_dout", tag, s), 16'(tr_d[s]), 16'(d));
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        v_in     = '0;
        ready_in = 1'b1;
        for (int l = 0; l < 4; l++) begin
            srcq[l].delete();
            acc_cnt[l] = 0;
        end
        out_q.delete();
        exp_q.delete();
        hs      = '0;
        gap_drv = '0;
        for (int s = 0; s < TRN; s++) rin_pat[s] = 1'b1;
        repeat (2) @(posedge clk_f);
        #1;
        reset = 1'b0;
    endtask

    // One iteration per clock: retire handshakes, drive sources, sample, then step the edge.
    task automatic run(input int n);
        logic [8:0] tmp;
        for (int s = 0; s < n; s++) begin
            for (int l = 0; l < 4; l++) begin
                if (srcq[l].size() > 0 && (hs[l] || gap_drv[l])) tmp = srcq[l].pop_front();
                gap_drv[l] = 1'b0;
                v_in[l]    = 1'b0;
                if (srcq[l].size() > 0) begin
                    tmp = srcq[l][0];
                    if (tmp[8]) gap_drv[l] = 1'b1;
                    else begin
                        v_in[l] = 1'b1;
                        d_in[l] = tmp[7:0];
                    end
                end
            end
            ready_in = rnd_rin ? ($urandom_range(0, 9) < 7) : ((s < TRN) ? rin_pat[s] : 1'b1);
            #1;
            if (s < TRN) begin
                tr_v[s] = valid_out;
                tr_d[s] = data_out;
                tr_g[s] = grant;
                tr_b[s] = busy;
                tr_r[s] = r_out;
            end
            hs = r_out & v_in;
            for (int l = 0; l < 4; l++) acc_cnt[l] += int'(hs[l]);
            chk("ready_onehot", 16'($countones(r_out) <= 1), 16'd1);
            if (valid_out && ready_in) begin
                out_q.push_back(data_out);
                if (use_exp) begin
                    if (exp_q.size() == 0) chk("stream_extra", 16'(data_out), 16'hFFFF);
                    else chk("stream", 16'(data_out), 16'(exp_q.pop_front()));
                end
            end
            @(posedge clk_f);
            #1;
        end
    endtask

    int len [4];
    int idx [4];
    int ptr, lane, take;

    initial begin
        reset    = 1'b1;
        ready_in = 1'b1;
        v_in     = '0;
        use_exp  = 1'b0;
        rnd_rin  = 1'b0;
        hs       = '0;
        gap_drv  = '0;
        for (int l = 0; l < 4; l++) d_in[l] = 8'h5a;

        // Reset held with every requester valid.
        v_in = 4'hF;
        repeat (3) @(posedge clk_f);
        #1;
        chk("rst_ready", 16'(r_out), 16'h0);
        chk("rst_vout", 16'(valid_out), 16'h0);
        chk("rst_dout", 16'(data_out), 16'h0);
        chk("rst_grant", 16'(grant), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        reset = 1'b0;
        @(posedge clk_f);
        #1;
        chk("first_grant", 16'(grant), 16'h0);
        chk("first_busy", 16'(busy), 16'h1);

        // Single lane, burst limit then one bubble then a fresh burst.
        do_reset();
        srcq[0].push_back(9'h0ff);
        srcq[0].push_back(9'h0ee);
        srcq[0].push_back(9'h0bb);
        srcq[0].push_back(9'h0aa);
        srcq[0].push_back(9'h011);
        run(9);
        chk_s("t2", 1, 1'b0, 8'h00);
        chk_s("t2", 2, 1'b1, 8'hff);
        chk_s("t2", 3, 1'b1, 8'hee);
        chk_s("t2", 4, 1'b1, 8'hbb);
        chk_s("t2", 5, 1'b1, 8'haa);
        chk_s("t2", 6, 1'b0, 8'h00);
        chk_s("t2", 7, 1'b1, 8'h11);
        chk_s("t2", 8, 1'b0, 8'h00);
        chk("t2_busy_s5", 16'(tr_b[5]), 16'h0);
        chk("t2_busy_s6", 16'(tr_b[6]), 16'h1);
        for (int s = 1; s < 9; s++) chk("t2_grant", 16'(tr_g[s]), 16'h0);

        // All four lanes contend: bursts of MB in lane order, twice around.
        do_reset();
        for (int l = 0; l < 4; l++)
            for (int k = 0; k < 8; k++) srcq[l].push_back(9'((l << 4) | k));
        for (int r = 0; r < 2; r++)
            for (int l = 0; l < 4; l++)
                for (int k = 0; k < MB; k++) exp_q.push_back(8'((l << 4) | (r * MB + k)));
        use_exp = 1'b1;
        run(60);
        use_exp = 1'b0;
        chk("t3_left", 16'(exp_q.size()), 16'd0);
        chk("t3_count", 16'(out_q.size()), 16'd32);

        // Downstream stall after the first beat of lane 2.
        do_reset();
        srcq[2].push_back(9'h0dd);
        srcq[2].push_back(9'h0cc);
        for (int s = 2; s <= 4; s++) rin_pat[s] = 1'b0;
        run(8);
        chk("t4_ready_s1", 16'(tr_r[1]), 16'h4);
        for (int s = 2; s <= 5; s++) chk_s("t4", s, 1'b1, 8'hdd);
        for (int s = 2; s <= 4; s++) chk("t4_ready_stall", 16'(tr_r[s]), 16'h0);
        chk("t4_ready_s5", 16'(tr_r[5]), 16'h4);
        chk_s("t4", 6, 1'b1, 8'hcc);
        chk_s("t4", 7, 1'b0, 8'h00);
        chk("t4_count", 16'(out_q.size()), 16'd2);
        if (out_q.size() == 2) begin
            chk("t4_beat0", 16'(out_q[0]), 16'h00dd);
            chk("t4_beat1", 16'(out_q[1]), 16'h00cc);
        end

        // Lane 1 runs dry after one beat; pointer moves past it to lane 3.
        do_reset();
        srcq[1].push_back(9'h099);
        srcq[1].push_back(9'h100);
        srcq[1].push_back(9'h09a);
        srcq[3].push_back(9'h077);
        run(9);
        chk("t5_grant_s1", 16'(tr_g[1]), 16'h1);
        chk_s("t5", 2, 1'b1, 8'h99);
        chk_s("t5", 3, 1'b0, 8'h00);
        chk("t5_busy_s3", 16'(tr_b[3]), 16'h0);
        chk("t5_grant_s4", 16'(tr_g[4]), 16'h3);
        chk_s("t5", 5, 1'b1, 8'h77);
        chk("t5_grant_s7", 16'(tr_g[7]), 16'h1);
        chk_s("t5", 8, 1'b1, 8'h9a);

        // Reset while a beat sits in the output register.
        do_reset();
        srcq[1].push_back(9'h011);
        srcq[3].push_back(9'h088);
        rin_pat[5] = 1'b0;
        run(6);
        chk_s("t6", 5, 1'b1, 8'h88);
        reset    = 1'b1;
        ready_in = 1'b0;
        @(posedge clk_f);
        #1;
        chk("t6_vout", 16'(valid_out), 16'h0);
        chk("t6_dout", 16'(data_out), 16'h0);
        chk("t6_busy", 16'(busy), 16'h0);
        chk("t6_grant", 16'(grant), 16'h0);
`ifdef LANE_RR_ARBITER_STATS_EN
        for (int l = 0; l < 4; l++) chk("t6_beats", beats[l], 16'h0);
`endif
        reset = 1'b0;
        v_in  = 4'b1010;
        @(posedge clk_f);
        #1;
        chk("t6_ptr_grant", 16'(grant), 16'h1);
        chk("t6_ptr_busy", 16'(busy), 16'h1);

        // Randomized traffic against a transaction-level round-robin model.
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int l = 0; l < 4; l++) begin
                len[l] = $urandom_range(0, 9);
                idx[l] = 0;
                for (int k = 0; k < len[l]; k++) srcq[l].push_back(9'($urandom_range(0, 255)));
            end
            ptr = 0;
            while (idx[0] < len[0] || idx[1] < len[1] || idx[2] < len[2] || idx[3] < len[3]) begin
                lane = -1;
                for (int k = 3; k >= 0; k--)
                    if (idx[(ptr + k) % 4] < len[(ptr + k) % 4]) lane = (ptr + k) % 4;
                take = (len[lane] - idx[lane] < MB) ? len[lane] - idx[lane] : MB;
                for (int k = 0; k < take; k++) exp_q.push_back(srcq[lane][idx[lane] + k][7:0]);
                idx[lane] += take;
                ptr = (lane + 1) % 4;
            end
            use_exp = 1'b1;
            rnd_rin = 1'b1;
            run(400);
            use_exp = 1'b0;
            rnd_rin = 1'b0;
            chk("rnd_left", 16'(exp_q.size()), 16'd0);
            for (int l = 0; l < 4; l++) begin
                chk("rnd_accepted", 16'(acc_cnt[l]), 16'(len[l]));
`ifdef LANE_RR_ARBITER_STATS_EN
                chk("rnd_beats", beats[l], 16'(len[l]));
`endif
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
